// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: valid/ready handshake over a main + skid register pair.
// Optional back-pressure stall counter enabled by defining PIPE_STAGE_STATS_EN.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no entry held; out_valid low, in_ready high
// ST_ONE   | main holds the head entry; skid unused
// ST_TWO   | main holds the head, skid holds the next entry
module pipe_stage_skid #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    if (DATA_W < 1 || CTRL_W < 1 || CNT_W < 1) begin : g_bad_params
        $error("pipe_stage_skid: DATA_W, CTRL_W and CNT_W must all be >= 1");
    end

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic                acc_in;
    logic                acc_out;

    // Ready comes from the state flop alone, so out_ready never reaches in_ready.
    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign acc_in    = in_valid & in_ready;
    assign acc_out   = out_valid & out_ready;
    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (acc_in) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc_in && acc_out) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (acc_in) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        state_d     = ST_TWO;
                    end else if (acc_out) begin
                        state_d     = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_ready) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        state_d     = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating; only reset clears it so stalls around a flush stay visible.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: FIFO model of accepted entries checked on every
// downstream transfer. Stall-counter checks are active when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_skid;

    localparam int DW        = 96;
    localparam int CW        = 9;
    localparam int SW        = 4;
    localparam int STALL_MAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
`ifdef PIPE_STAGE_STATS_EN
    logic [SW-1:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    int exp_stall = 0;
    bit mon_en = 1'b0;
    logic [DW+CW-1:0] sb[$];

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle monitor: checks outputs against the model, then applies the transfers
    // that the coming rising edge will perform.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [DW+CW-1:0] head;
            int               occ;
            occ = sb.size();
            chk("out_valid", out_valid, occ != 0);
            chk("in_ready", in_ready, occ != 2);
            if (occ == 0) chk("bubble_ctrl", out_ctrl, 0);
`ifdef PIPE_STAGE_STATS_EN
            chk("stall_cnt", stall_cnt, exp_stall);
`endif
            if (reset) begin
                sb.delete();
                exp_stall = 0;
            end else begin
                if (occ != 0 && !out_ready && exp_stall < STALL_MAX) exp_stall++;
                if (flush) begin
                    sb.delete();
                end else begin
                    if (occ != 0 && out_ready) begin
                        head = sb.pop_front();
                        chk("out_data", out_data, head[DW+CW-1:CW]);
                        chk("out_ctrl", out_ctrl, head[CW-1:0]);
                        n_out++;
                    end
                    if (in_valid && occ != 2) sb.push_back({in_data, in_ctrl});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int  n0;
        bit  taken;

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(32'h77);
        in_ctrl   = CW'(3);
        out_ready = 1'b0;
        step();
        mon_en = 1'b1;
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
`ifdef PIPE_STAGE_STATS_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
        reset    = 1'b0;
        in_valid = 1'b0;
        step();

        // Single transfer
        in_valid  = 1'b1;
        in_data   = DW'(32'h1234);
        in_ctrl   = CW'(9'h1FF);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 'h1234);
        chk("single_ctrl", out_ctrl, 'h1FF);
        step();
        chk("single_after_valid", out_valid, 0);
        chk("single_after_ctrl", out_ctrl, 0);

        // Back-pressure: A, B fill both registers, C must wait
        n0        = n_out;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(32'hA);
        in_ctrl   = CW'(9'h0A);
        step();
        in_data = DW'(32'hB);
        in_ctrl = CW'(9'h0B);
        step();
        chk("bp_full_ready", in_ready, 0);
        in_data = DW'(32'hC);
        in_ctrl = CW'(9'h0C);
        step();
        step();
        chk("bp_c_held_ready", in_ready, 0);
        chk("bp_head_a", out_data, 'hA);
        out_ready = 1'b1;
        taken     = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (in_ready) begin
                taken = 1'b1;
                break;
            end
        end
        chk("bp_c_taken", taken, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) step();
        chk("bp_out_count", n_out - n0, 3);

        // Streaming 1..8 with downstream always ready
        n0 = n_out;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            in_ctrl  = CW'(i * 37 + 1);
            chk("stream_in_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        chk("stream_out_count", n_out - n0, 8);

        // Flush while holding two entries, with 0x5 offered on the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(32'h21);
        in_ctrl   = CW'(9'h121);
        step();
        in_data = DW'(32'h22);
        in_ctrl = CW'(9'h122);
        step();
        chk("flush_pre_full", in_ready, 0);
        in_data = DW'(32'h5);
        in_ctrl = CW'(9'h105);
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_ctrl", out_ctrl, 0);
        chk("flush_in_ready", in_ready, 1);
        n0        = n_out;
        out_ready = 1'b1;
        repeat (3) step();
        chk("flush_no_output", n_out - n0, 0);

        // Long stall, flush, then reset while an entry is held
        reset = 1'b1;
        step();
        reset = 1'b0;
`ifdef PIPE_STAGE_STATS_EN
        chk("stats_clear", stall_cnt, 0);
`endif
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(32'h3C);
        in_ctrl   = CW'(9'h03C);
        step();
        in_valid = 1'b0;
        repeat (20) step();
        chk("stall_head", out_data, 'h3C);
`ifdef PIPE_STAGE_STATS_EN
        chk("stats_saturate", stall_cnt, STALL_MAX);
`endif
        flush = 1'b1;
        step();
        flush = 1'b0;
`ifdef PIPE_STAGE_STATS_EN
        chk("stats_after_flush", stall_cnt, STALL_MAX);
`endif
        in_valid = 1'b1;
        in_data  = DW'(32'h4D);
        in_ctrl  = CW'(9'h04D);
        step();
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
`ifdef PIPE_STAGE_STATS_EN
        chk("stats_after_reset", stall_cnt, 0);
`endif
        out_ready = 1'b1;
        repeat (3) step();
        chk("sb_empty", sb.size(), 0);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised elastic pipeline stage register. It is the successor to the fixed, write-enable-gated inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a generic DATA_W payload plus a CTRL_W control bundle (regWrite, memRead, memWrite, branch, etc.).
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops or duplicates an instruction.
- Synchronous flush turns the stage into a bubble (all control bits zeroed).
- Sits between any two CPU pipeline stages; the hazard unit drives out_ready and flush.

Parameters:
- DATA_W, 96: payload width (pc, operands, imm, reg indices packed by the instantiating stage); must be ≥ 1.
- CTRL_W, 9: control bundle width; zeroed on reset, flush and bubble; must be ≥ 1.
- CNT_W, 16: width of the stall counter (used only with the optional feature).

Ports:
- clk, input, 1: clock, rising-edge.
- reset, input, 1: reset, synchronous, active-high.
- flush, input, 1: synchronous squash of all held entries.
- in_valid, input, 1: upstream holds a valid instruction.
- in_ready, output, 1: stage can accept this cycle.
- in_data, input, DATA_W: upstream payload.
- in_ctrl, input, CTRL_W: upstream control bundle.
- out_valid, output, 1: stage presents a valid instruction.
- out_ready, input, 1: downstream accepts this cycle.
- out_data, output, DATA_W: payload of the head entry.
- out_ctrl, output, CTRL_W: control of the head entry; all zero whenever out_valid = 0.
- stall_cnt, output, CNT_W: saturating back-pressure cycle count (only when PIPE_STAGE_STATS_EN is defined).

Behaviour:
- Storage:
  - main register (head): drives out_data/out_ctrl.
  - skid register.
  - 2-bit state: EMPTY, ONE, TWO.
- Handshake:
  - Accept in = in_valid & in_ready.
  - Accept out = out_valid & out_ready.
  - in_ready = (state != TWO), decoded from the state flop only; no combinational path from out_ready.
  - out_valid = (state != EMPTY).
- Transitions (no flush):
  - EMPTY: accept in → main ← in, go to ONE.
  - ONE: in & out → main ← in, stay ONE.
  - ONE: in only → skid ← in, go to TWO.
  - ONE: out only → go to EMPTY.
  - TWO: out_ready → main ← skid, go to ONE. in_ready = 0, so no input is taken that cycle.
  - TWO: otherwise hold.
- Latency:
  - 1 cycle from accept-in to out_valid when EMPTY.
  - Sustained throughput 1 per cycle with out_ready held high.
  - Order is strictly FIFO.
- out_ctrl is forced to 0 whenever out_valid = 0 (a bubble presents NOP control).
- Flush:
  - Next state EMPTY; main and skid ctrl ← 0; data registers hold their value.
  - Same-cycle in_valid is dropped, even though in_ready may be 1.
  - Same-cycle out_ready is ignored; the downstream must not treat that cycle as a transfer.
- Reset:
  - Overrides flush.
  - State EMPTY; main/skid data and ctrl ← 0; stall_cnt ← 0.
  - Outputs after reset: out_valid 0, in_ready 1, out_data 0, out_ctrl 0.
  - Reset mid-operation discards all held entries.
- Registers update only on clk rising edge. The block contains no write-enable input; stalling is expressed solely through out_ready.

Optional Feature:
PIPE_STAGE_STATS_EN
- Defined:
  - stall_cnt port exists.
  - Increments by 1 each cycle with out_valid = 1 and out_ready = 0.
  - Saturates at 2^CNT_W−1.
  - Cleared by reset only; not cleared by flush.
- Undefined: stall_cnt port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert reset 2 cycles with in_valid = 1 → out_valid 0, in_ready 1, out_data 0, out_ctrl 0, stall_cnt 0.
- Single transfer: in_data 0x1234, in_ctrl 0x1FF, in_valid 1 cycle, out_ready 1 → next cycle out_valid 1, out_data 0x1234, out_ctrl 0x1FF; following cycle out_valid 0, out_ctrl 0.
- Back-pressure: out_ready 0; push A = 0xA, B = 0xB on consecutive cycles → in_ready 0 after B; C held at input is not taken. Raise out_ready → outputs A, B, C in order, no loss or duplication.
- Streaming: 8 back-to-back words 1..8 with out_ready = 1 → outputs 1..8 on consecutive cycles, in_ready stays 1.
- Flush while TWO, with in_valid = 1 carrying 0x5: → next cycle out_valid 0, out_ctrl 0, in_ready 1. 0x5 never appears at the output.
- Stats (PIPE_STAGE_STATS_EN, CNT_W = 4): hold out_valid 1, out_ready 0 for 20 cycles → stall_cnt saturates at 15. A flush leaves it at 15; a reset clears it to 0.
